// File: rtl/runner_pkg.sv
// runner_pkg: default widths and ALU op encoding shared by runner and runner_alu.
package runner_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_OR  = 2'd3
    } op_e;

endpackage

// File: rtl/runner_alu.sv
// runner_alu: combinational add/sub/and/or; RUNNER_FLAGS_EN adds {N,Z,C,V} flags.
module runner_alu
    import runner_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  op_e                   i_op,
    output logic [DATA_WIDTH-1:0] o_result
`ifdef RUNNER_FLAGS_EN
    ,
    output logic [3:0]            o_flags
`endif
);

    always_comb
        o_result = i_op == OP_ADD ? i_a + i_b :
                   i_op == OP_SUB ? i_a - i_b :
                   i_op == OP_AND ? i_a & i_b :
                                    i_a | i_b;

`ifdef RUNNER_FLAGS_EN
    localparam int MSB = DATA_WIDTH - 1;

    logic [DATA_WIDTH:0] w_add;
    logic [DATA_WIDTH:0] w_sub;
    logic                w_arith;
    logic                w_c;
    logic                w_v;

    // Subtract as A + ~B + 1 so the top bit is the no-borrow flag directly.
    assign w_add   = {1'b0, i_a} + {1'b0, i_b};
    assign w_sub   = {1'b0, i_a} + {1'b0, ~i_b} + {{DATA_WIDTH{1'b0}}, 1'b1};
    assign w_arith = i_op == OP_ADD || i_op == OP_SUB;

    always_comb begin
        w_c = i_op == OP_ADD ? w_add[DATA_WIDTH] :
              i_op == OP_SUB ? w_sub[DATA_WIDTH] : 1'b0;
        w_v = !w_arith ? 1'b0 :
              i_op == OP_ADD ? (i_a[MSB] == i_b[MSB]) && (o_result[MSB] != i_a[MSB]) :
                               (i_a[MSB] != i_b[MSB]) && (o_result[MSB] != i_a[MSB]);
    end

    assign o_flags = {o_result[MSB], o_result == '0, w_c, w_v};
`endif

endmodule

// File: rtl/runner.sv
// runner: register file feeding an ALU whose result is written back every clock.
// Optional RUNNER_FLAGS_EN exposes the ALU {N,Z,C,V} flags as an extra output.
module runner
    import runner_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr1,
    input  logic [ADDR_WIDTH-1:0] rd_addr2,
    output logic [DATA_WIDTH-1:0] rd_data1,
    output logic [DATA_WIDTH-1:0] rd_data2,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  clk,
    input  logic [1:0]            s,
    input  logic                  rst_n
`ifdef RUNNER_FLAGS_EN
    ,
    output logic [3:0]            flags
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [DEPTH];

    assign rd_data1 = r_regs[rd_addr1];
    assign rd_data2 = r_regs[rd_addr2];

    runner_alu #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_alu (
        .i_a      (rd_data1),
        .i_b      (rd_data2),
        .i_op     (op_e'(s)),
        .o_result (wr_data)
`ifdef RUNNER_FLAGS_EN
        ,
        .o_flags  (flags)
`endif
    );

    // Reset preloads each register with its own index; no write enable, so
    // every clock outside reset stores the ALU result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                r_regs[i] <= DATA_WIDTH'(i);
        end else begin
            r_regs[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_runner.sv
// tb_runner: directed self-checking bench for runner (flag checks when RUNNER_FLAGS_EN is defined).
module tb_runner;

    logic [4:0]  wr_addr;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic [31:0] wr_data;
    logic        clk;
    logic [1:0]  s;
    logic        rst_n;
`ifdef RUNNER_FLAGS_EN
    logic [3:0]  flags;
`endif

    int checks;
    int errors;

    runner dut (
        .wr_addr  (wr_addr),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2),
        .wr_data  (wr_data),
        .clk      (clk),
        .s        (s),
        .rst_n    (rst_n)
`ifdef RUNNER_FLAGS_EN
        ,
        .flags    (flags)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_in(input logic [4:0] w, input logic [4:0] a1, input logic [4:0] a2, input logic [1:0] op);
        wr_addr  = w;
        rd_addr1 = a1;
        rd_addr2 = a2;
        s        = op;
    endtask

    task automatic apply_reset;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0;
        set_in(5'd2, 5'd0, 5'd31, 2'd0);
        #1;
        checks++;
        if (rd_data1 !== 32'd0) begin
            $display("FAIL reset_r0: got %0d want 0", rd_data1); errors++;
        end
        checks++;
        if (rd_data2 !== 32'd31) begin
            $display("FAIL reset_r31: got %0d want 31", rd_data2); errors++;
        end
        checks++;
        if (wr_data !== 32'd31) begin
            $display("FAIL reset_wr_data: got %0d want 31", wr_data); errors++;
        end
        // Clock edges during reset must not write register 2.
        @(posedge clk);
        #1;
        rd_addr1 = 5'd2;
        #1;
        checks++;
        if (rd_data1 !== 32'd2) begin
            $display("FAIL reset_no_write: got %0d want 2", rd_data1); errors++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add;
        apply_reset();
        set_in(5'd6, 5'd10, 5'd5, 2'd0);
        #1;
        checks++;
        if (rd_data1 !== 32'd10) begin
            $display("FAIL add_rd1: got %0d want 10", rd_data1); errors++;
        end
        checks++;
        if (rd_data2 !== 32'd5) begin
            $display("FAIL add_rd2: got %0d want 5", rd_data2); errors++;
        end
        checks++;
        if (wr_data !== 32'd15) begin
            $display("FAIL add_wr_data: got %0d want 15", wr_data); errors++;
        end
`ifdef RUNNER_FLAGS_EN
        checks++;
        if (flags !== 4'b0000) begin
            $display("FAIL add_flags: got %b want 0000", flags); errors++;
        end
`endif
        @(posedge clk);
        #1;
        rd_addr1 = 5'd6;
        #1;
        checks++;
        if (rd_data1 !== 32'd15) begin
            $display("FAIL add_writeback: got %0d want 15", rd_data1); errors++;
        end
    endtask

    task automatic test_sub;
        apply_reset();
        set_in(5'd1, 5'd24, 5'd12, 2'd1);
        #1;
        checks++;
        if (wr_data !== 32'd12) begin
            $display("FAIL sub_wr_data: got %0d want 12", wr_data); errors++;
        end
`ifdef RUNNER_FLAGS_EN
        checks++;
        if (flags !== 4'b0010) begin
            $display("FAIL sub_flags: got %b want 0010", flags); errors++;
        end
`endif
        @(posedge clk);
        #1;
        rd_addr2 = 5'd1;
        #1;
        checks++;
        if (rd_data2 !== 32'd12) begin
            $display("FAIL sub_writeback: got %0d want 12", rd_data2); errors++;
        end
    endtask

    task automatic test_logic;
        apply_reset();
        set_in(5'd8, 5'd28, 5'd19, 2'd2);
        #1;
        checks++;
        if (wr_data !== 32'd16) begin
            $display("FAIL and_wr_data: got %0d want 16", wr_data); errors++;
        end
        @(posedge clk);
        #1;
        set_in(5'd30, 5'd17, 5'd29, 2'd3);
        #1;
        checks++;
        if (wr_data !== 32'd29) begin
            $display("FAIL or_wr_data: got %0d want 29", wr_data); errors++;
        end
        rd_addr2 = 5'd8;
        #1;
        checks++;
        if (rd_data2 !== 32'd16) begin
            $display("FAIL and_writeback: got %0d want 16", rd_data2); errors++;
        end
`ifdef RUNNER_FLAGS_EN
        checks++;
        if (flags !== 4'b0000) begin
            $display("FAIL or_flags: got %b want 0000", flags); errors++;
        end
`endif
    endtask

    task automatic test_wrap;
        apply_reset();
        set_in(5'd31, 5'd0, 5'd1, 2'd1);
        #1;
        checks++;
        if (wr_data !== 32'hFFFF_FFFF) begin
            $display("FAIL wrap_wr_data: got %h want ffffffff", wr_data); errors++;
        end
`ifdef RUNNER_FLAGS_EN
        checks++;
        if (flags !== 4'b1000) begin
            $display("FAIL wrap_flags: got %b want 1000", flags); errors++;
        end
        s = 2'd0;
        rd_addr2 = 5'd0;
        #1;
        checks++;
        if (flags !== 4'b0100) begin
            $display("FAIL zero_flags: got %b want 0100", flags); errors++;
        end
`endif
    endtask

    task automatic test_reg0;
        apply_reset();
        set_in(5'd0, 5'd31, 5'd0, 2'd3);
        @(posedge clk);
        #1;
        rd_addr1 = 5'd0;
        #1;
        checks++;
        if (rd_data1 !== 32'd31) begin
            $display("FAIL reg0_write: got %0d want 31", rd_data1); errors++;
        end
    endtask

    task automatic test_accum;
        logic [31:0] exp;
        apply_reset();
        set_in(5'd3, 5'd3, 5'd3, 2'd0);
        exp = 32'd3;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (wr_data !== exp * 2) begin
                $display("FAIL accum_wr_data%0d: got %0d want %0d", k, wr_data, exp * 2); errors++;
            end
            @(posedge clk);
            #1;
            exp = exp * 2;
            checks++;
            if (rd_data1 !== exp) begin
                $display("FAIL accum_step%0d: got %0d want %0d", k, rd_data1, exp); errors++;
            end
        end
    endtask

    task automatic test_back_to_back;
        apply_reset();
        set_in(5'd10, 5'd2, 5'd3, 2'd0);
        @(posedge clk);
        #1;
        set_in(5'd11, 5'd10, 5'd4, 2'd1);
        #1;
        checks++;
        if (wr_data !== 32'd1) begin
            $display("FAIL b2b_chain: got %0d want 1", wr_data); errors++;
        end
        @(posedge clk);
        #1;
        set_in(5'd20, 5'd10, 5'd11, 2'd2);
        #1;
        checks++;
        if (rd_data1 !== 32'd5 || rd_data2 !== 32'd1) begin
            $display("FAIL b2b_regs: got %0d,%0d want 5,1", rd_data1, rd_data2); errors++;
        end
    endtask

    task automatic test_async_reset;
        apply_reset();
        set_in(5'd6, 5'd10, 5'd5, 2'd0);
        @(posedge clk);
        #1;
        rd_addr1 = 5'd6;
        #1;
        checks++;
        if (rd_data1 !== 32'd15) begin
            $display("FAIL areset_pre: got %0d want 15", rd_data1); errors++;
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rd_data1 !== 32'd6) begin
            $display("FAIL areset_immediate: got %0d want 6", rd_data1); errors++;
        end
        set_in(5'd6, 5'd10, 5'd5, 2'd0);
        #1;
        checks++;
        if (wr_data !== 32'd15) begin
            $display("FAIL areset_wr_data: got %0d want 15", wr_data); errors++;
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rd_addr1 = 5'd6;
        #1;
        checks++;
        if (rd_data1 !== 32'd6) begin
            $display("FAIL areset_blocked: got %0d want 6", rd_data1); errors++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        rd_addr1 = 5'd10;
        @(posedge clk);
        #1;
        rd_addr1 = 5'd6;
        #1;
        checks++;
        if (rd_data1 !== 32'd15) begin
            $display("FAIL areset_first_write: got %0d want 15", rd_data1); errors++;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        set_in(5'd0, 5'd0, 5'd0, 2'd0);
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_wrap();
        test_reg0();
        test_accum();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/runner.md
RUNNER -- requirements
Module: runner

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sets the register and data-path width in bits.
REQ-002 Parameter ADDR_WIDTH, default 5, sets the register-address width; depth is 2**ADDR_WIDTH (32).
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 wr_addr  input  ADDR_WIDTH  destination register for the ALU result.
REQ-007 rd_addr1  input  ADDR_WIDTH  source register for operand A.
REQ-008 rd_addr2  input  ADDR_WIDTH  source register for operand B.
REQ-009 rd_data1  output  DATA_WIDTH  contents of register rd_addr1 (operand A).
REQ-010 rd_data2  output  DATA_WIDTH  contents of register rd_addr2 (operand B).
REQ-011 wr_data  output  DATA_WIDTH  ALU result; this value is written to wr_addr.
REQ-012 s  input  2  ALU operation select.
REQ-013 Port order SHALL be wr_addr, rd_addr1, rd_addr2, rd_data1, rd_data2, wr_data, clk, s, rst_n.

Function
REQ-014 Register file SHALL hold 2**ADDR_WIDTH registers of DATA_WIDTH bits; all registers SHALL be writable, including register 0.
REQ-015 rd_data1 and rd_data2 SHALL be combinational reads of the addressed registers, with zero-cycle latency.
REQ-016 wr_data SHALL be a combinational function of rd_data1 (A), rd_data2 (B) and s: 0 gives A+B, 1 gives A-B, 2 gives A&B, and 3 gives A|B.
REQ-017 Add and subtract SHALL wrap modulo 2**DATA_WIDTH, and carry/borrow SHALL be discarded on wr_data.
REQ-018 On every rising clk edge while rst_n is high, register[wr_addr] SHALL load wr_data; there is no write enable.
REQ-019 Reads SHALL return pre-edge contents. A new value SHALL be visible on rd_data* immediately after the edge that writes it.
REQ-020 When wr_addr equals rd_addr1 or rd_addr2, the write SHALL use the pre-edge operand. The result SHALL then feed back in the next cycle, giving accumulator behaviour.
REQ-021 Outputs SHALL contain no X when all inputs are known.

Reset
REQ-022 While rst_n is low, every register i SHALL hold the value i, zero-extended to DATA_WIDTH, and writes SHALL be blocked.
REQ-023 Reset assertion SHALL take effect immediately, without a clock edge. rd_data* and wr_data SHALL then reflect the reset contents combinationally.
REQ-024 Reset deassertion SHALL be followed by a normal write at the first rising edge with rst_n high.

Configuration
REQ-025 Macro RUNNER_FLAGS_EN, when defined, SHALL add an output port flags [3:0] = {N, Z, C, V} after rst_n.
- N is wr_data MSB.
- Z is set when wr_data == 0.
- C is the carry-out of the add or the no-borrow of the subtract, and 0 for the logic ops.
- V is signed overflow for add/sub, and 0 for the logic ops.
REQ-026 Without RUNNER_FLAGS_EN, the flags port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-027 Package runner_pkg SHALL hold the default width constants and an enumerated op type: OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3.
REQ-028 The ALU SHALL be a sub-module runner_alu (A, B, op, result, optional flags). The register-file storage SHALL stay in runner.

Verification
REQ-029 Reset, then rd1=10, rd2=5, wr=6, s=0 -> rd_data1=10, rd_data2=5, wr_data=15; after the edge, register 6 reads 15.
REQ-030 Reset, then rd1=24, rd2=12, wr=1, s=1 -> wr_data=12; after the edge, register 1 reads 12.
REQ-031 Reset, then rd1=28, rd2=19, wr=8, s=2 -> wr_data=16; then rd1=17, rd2=29, wr=30, s=3 -> wr_data=29.
REQ-032 Reset, then rd1=0, rd2=1, s=1 -> wr_data=0xFFFFFFFF (wrap); with RUNNER_FLAGS_EN, flags N=1, Z=0, C=0, V=0.
REQ-033 Reset, then rd1=rd2=wr=3, s=0 for 3 edges -> register 3 steps 6, 12, 24.
REQ-034 Write register 6=15, then assert rst_n low between edges -> register 6 reads 6 immediately; no writes occur while rst_n is low.
